// File: rtl/uart_tx_buffered_if.sv
// Bundles the byte-write, start/done handshake, baud tick and status lines of
// the buffered UART transmitter.
//   master : the debug unit side (drives i_*, observes o_*)
//   slave  : the transmitter itself
interface uart_tx_buffered_if #(
  parameter int NB_UART_DATA = 8
);
  logic                    i_wr;
  logic [NB_UART_DATA-1:0] i_wdata;
  logic                    i_tx_start;
  logic                    i_tick;
  logic                    o_tx;
  logic                    o_tx_done;
  logic                    o_full;
  logic                    o_empty;
  logic                    o_busy;

  modport master (
    output i_wr, i_wdata, i_tx_start, i_tick,
    input  o_tx, o_tx_done, o_full, o_empty, o_busy
  );

  modport slave (
    input  i_wr, i_wdata, i_tx_start, i_tick,
    output o_tx, o_tx_done, o_full, o_empty, o_busy
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Bytes are queued in a FIFO; a start request
// sends everything queued (including bytes added meanwhile) and then pulses
// o_tx_done once the FIFO has drained. Bit timing uses an external 16x tick.
// Ports:
//   clk            system clock, rising edge
//   i_rst          asynchronous active-high reset
//   bus.i_wr       enqueue bus.i_wdata (dropped while o_full)
//   bus.i_tx_start request to transmit until the FIFO is empty
//   bus.i_tick     baud tick at NB_TICKS_PER_BIT x bit rate
//   bus.o_tx       registered serial line, idle high
//   bus.o_tx_done  one-cycle burst-complete pulse
//   bus.o_full / bus.o_empty  FIFO status
//   bus.o_busy     burst pending or frame in progress
module uart_tx_buffered #(
  parameter int NB_UART_DATA     = 8,
  parameter int FIFO_ADDR_WIDTH  = 4,
  parameter int NB_TICKS_PER_BIT = 16
) (
  input logic               clk,
  input logic               i_rst,
  uart_tx_buffered_if.slave bus
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int CW    = FIFO_ADDR_WIDTH + 1;
  localparam int TW    = (NB_TICKS_PER_BIT > 1) ? $clog2(NB_TICKS_PER_BIT) : 1;
  localparam int BW    = (NB_UART_DATA > 1) ? $clog2(NB_UART_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(NB_TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_UART_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [NB_UART_DATA-1:0]    mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       full, empty, push, pop;

  state_t                     state, state_nx;
  logic [TW-1:0]              tick_cnt, tick_nx;
  logic [BW-1:0]              bit_cnt, bit_nx;
  logic [NB_UART_DATA-1:0]    shreg, shreg_nx;
  logic                       tx_reg, tx_nx;
  logic                       send, done;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Full is the registered value, so a write while full is lost even if
  // the serializer pops in the same cycle.
  assign push  = bus.i_wr && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_wdata;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                send <= 1'b0;
    else if (done)            send <= 1'b0;
    else if (bus.i_tx_start)  send <= 1'b1;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_reg   <= 1'b1;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      tx_reg   <= tx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    pop      = 1'b0;
    done     = 1'b0;
    tx_nx    = 1'b1;

    case (state)
      IDLE: begin
        if (send && !empty) begin
          pop      = 1'b1;
          shreg_nx = mem[rd_ptr];
          tick_nx  = '0;
          bit_nx   = '0;
          state_nx = START;
        end else if (send) begin
          done = 1'b1;
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            state_nx = DATA;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            shreg_nx = shreg >> 1;
            if (bit_cnt == BIT_LAST) state_nx = STOP;
            else                     bit_nx   = bit_cnt + 1'b1;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            state_nx = IDLE;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Line level is decoded from the next state so the register output
    // changes in the same cycle as the state.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  assign bus.o_tx      = tx_reg;
  assign bus.o_tx_done = done;
  assign bus.o_full    = full;
  assign bus.o_empty   = empty;
  assign bus.o_busy    = send || (state != IDLE);

endmodule
